// File: rtl/mem_responder.sv
// Memory-side responder: accepts single-cycle read/write strobes, inserts
// WAIT_CYCLES wait states, then completes against an internal register file.
module mem_responder #(
   parameter int ADDR_W      = 4,
   parameter int DATA_W      = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              read,
   input  logic              write,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              rvalid,
   output logic              wack,
   output logic              busy,
   output logic              err,
   output logic              overrun
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      RESPOND = 2'd2
   } state_e;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_e;

   localparam int         DEPTH      = 2 ** ADDR_W;
   localparam int         CNT_INIT_I = (WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0;
   localparam logic [3:0] CNT_INIT   = CNT_INIT_I[3:0];
   localparam bit         HAS_WAIT   = (WAIT_CYCLES > 0);

   state_e              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   op_e                 op_q, op_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                rvalid_q, rvalid_d;
   logic                wack_q, wack_d;
   logic                err_q, err_d;
   logic                overrun_q, overrun_d;
   logic                mem_we_s;
   logic [DATA_W-1:0]   mem_q [DEPTH];

   // Next-state and registered-output decode.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      op_d      = op_q;
      rdata_d   = rdata_q;
      rvalid_d  = 1'b0;
      wack_d    = 1'b0;
      err_d     = 1'b0;
      mem_we_s  = 1'b0;
      // Any strobe while an access is in flight is dropped but remembered.
      overrun_d = overrun_q | ((state_q != IDLE) & (read | write));

      case (state_q)
         IDLE: begin
            if (read && write) begin
               err_d = 1'b1;
            end else if (read || write) begin
               addr_d = addr;
               op_d   = write ? OP_WR : OP_RD;
               if (write) begin
                  wdata_d = wdata;
               end else begin
                  wdata_d = wdata_q;
               end
               if (HAS_WAIT) begin
                  state_d = ACCESS;
                  cnt_d   = CNT_INIT;
               end else begin
                  state_d = RESPOND;
                  cnt_d   = 4'd0;
               end
            end else begin
               state_d = IDLE;
            end
         end
         ACCESS: begin
            if (cnt_q == 4'd0) begin
               state_d = RESPOND;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESPOND: begin
            state_d = IDLE;
            if (op_q == OP_RD) begin
               rdata_d  = mem_q[addr_q];
               rvalid_d = 1'b1;
            end else begin
               mem_we_s = 1'b1;
               wack_d   = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control and output registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= 4'd0;
         addr_q    <= {ADDR_W{1'b0}};
         wdata_q   <= {DATA_W{1'b0}};
         op_q      <= OP_RD;
         rdata_q   <= {DATA_W{1'b0}};
         rvalid_q  <= 1'b0;
         wack_q    <= 1'b0;
         err_q     <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         op_q      <= op_d;
         rdata_q   <= rdata_d;
         rvalid_q  <= rvalid_d;
         wack_q    <= wack_d;
         err_q     <= err_d;
         overrun_q <= overrun_d;
      end
   end

   // Register-file storage; reset clears every word so aborted writes leave no trace.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {DATA_W{1'b0}};
         end
      end else begin
         if (mem_we_s) begin
            mem_q[addr_q] <= wdata_q;
         end
      end
   end

   assign rdata   = rdata_q;
   assign rvalid  = rvalid_q;
   assign wack    = wack_q;
   assign err     = err_q;
   assign overrun = overrun_q;
   assign busy    = (state_q != IDLE);

endmodule
